// File: rtl/multicycle_control_unit.sv
// Purpose : Moore FSM sequencing the multi-cycle RV32I datapath (memory, IR, PC, ALU muxes, regfile).
// Latency : outputs are a function of the current state only; CPI 3+W .. 5+2W with W = MEM_WAIT_CYCLES.
// Backpr. : none; memory states hold for MEM_WAIT_CYCLES extra cycles, HALT holds until reset.
// Ports   : clk/reset (sync, active-high); opcode, bcond, is_halted in; is_ecall, reg_write,
//           mem_read, mem_write, i_or_d, ir_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//           pc_write, halted, state out.
module multicycle_control_unit #(
    parameter int MEM_WAIT_CYCLES = 0,
    parameter int WAIT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       is_halted,
    output logic       is_ecall,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_EX_ADDR  = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_EX_BR    = 4'd9,
        S_BR_TAKEN = 4'd10,
        S_EX_JAL   = 4'd11,
        S_EX_JALR  = 4'd12,
        S_ECALL    = 4'd13,
        S_PC_INC   = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, halted_d;
    logic              last;

    // A wait state completes once it has spent MEM_WAIT_CYCLES extra cycles.
    assign last   = (wait_q == WAIT_LAST);
    assign halted = halted_q;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IF;
            wait_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        // Counter only advances while a wait state is stalling; leaving any state
        // zeroes it, so every entry to IF/MEM_RD/MEM_WR starts from 0.
        wait_d     = '0;
        is_ecall   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = last;
                if (last) state_d = S_ID;
                else      wait_d  = wait_q + WAIT_W'(1);
            end
            S_ID: begin
                alu_src_b = 2'b01;
                case (opcode)
                    OP_R:              state_d = S_EX_R;
                    OP_I:              state_d = S_EX_I;
                    OP_LOAD, OP_STORE: state_d = S_EX_ADDR;
                    OP_BR:             state_d = S_EX_BR;
                    OP_JAL:            state_d = S_EX_JAL;
                    OP_JALR:           state_d = S_EX_JALR;
                    OP_ECALL:          state_d = S_ECALL;
                    default:           state_d = S_PC_INC;
                endcase
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EX_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (last) state_d = S_WB_MEM;
                else      wait_d  = wait_q + WAIT_W'(1);
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (last) state_d = S_PC_INC;
                else      wait_d  = wait_q + WAIT_W'(1);
            end
            S_WB_ALU, S_WB_MEM, S_PC_INC: begin
                reg_write  = (state_q != S_PC_INC);
                mem_to_reg = (state_q == S_WB_MEM);
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_d    = S_IF;
            end
            S_EX_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                state_d   = bcond ? S_BR_TAKEN : S_PC_INC;
            end
            S_BR_TAKEN: begin
                pc_write  = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_IF;
            end
            S_EX_JAL, S_EX_JALR: begin
                // rd <= ALUOut, which still holds PC+4 from ID.
                reg_write = 1'b1;
                pc_write  = 1'b1;
                alu_src_a = (state_q == S_EX_JALR);
                alu_src_b = 2'b10;
                state_d   = S_IF;
            end
            S_ECALL: begin
                is_ecall = 1'b1;
                if (is_halted) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = S_PC_INC;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IF;
        endcase

        // Reset aborts the instruction immediately: no write may leak out this cycle.
        if (reset) begin
            is_ecall  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule
